mc_cpu: RTL and testbench
=========================

Name: mc_cpu

Overview:
- Multi-cycle MIPS-subset core; parametrised successor to the single-cycle CPU.
- One unified memory port is shared by instruction fetch and data access, arbitrated by an internal FSM.
- Memory accepts variable latency via a req/ready handshake.
- Sits at the top of the CPU hierarchy; instantiates its own register file; ALU and sign-extension are inline.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_ADDR_WIDTH, 32, width of mem_addr; the byte address is truncated to its low MEM_ADDR_WIDTH bits.
- HALT_ON_ILLEGAL, 1, illegal-opcode handling: 1 = enter HALT; 0 = treat as NOP and continue.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_req  output  1  memory request valid; held until mem_ready is seen.
- mem_we  output  1  1 = write (sw), 0 = read; valid while mem_req is high.
- mem_addr  output  MEM_ADDR_WIDTH  byte address; stable while mem_req is high.
- mem_wdata  output  32  store data; stable while mem_req and mem_we are high.
- mem_rdata  input  32  read data; sampled in the cycle mem_ready is high.
- mem_ready  input  1  transfer completes in any cycle where mem_req and mem_ready are both high.
- pc_out  output  32  architectural PC of the next instruction to fetch.
- halted  output  1  high while the FSM is in HALT.
- state_out  output  3  current FSM state encoding; debug only.

Behaviour:
- Reset (asynchronous):
  - PC = RESET_PC; state = FETCH; IR = 0; A = B = ALUOut = MDR = 0.
  - mem_req = 0; mem_we = 0; halted = 0.
  - Register file contents are not cleared.
  - Reset during an outstanding request drops mem_req immediately. Memory must tolerate an abandoned request.
- Supported instructions:
  - R-type: add, sub, slt, jr.
  - I-type: addi, xori, lw, sw, beq, bne.
  - J-type: j, jal.
  - Arithmetic is 32-bit two's complement with wraparound; overflow is ignored (no trap).
  - slt is a signed compare.
  - Immediates are sign-extended, except xori, which zero-extends.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - mem_req = 1, mem_we = 0, mem_addr = PC.
  - On mem_ready: IR <= mem_rdata; PC <= PC+4; go to DECODE. Otherwise stay.
- DECODE:
  - A <= R[rs]; B <= R[rt].
  - An illegal opcode/funct goes to HALT if HALT_ON_ILLEGAL, else to FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - ALU on A and (B or ext(imm)).
  - beq/bne: taken means PC <= PC + (sext(imm)<<2). PC here is already incremented. Then go to FETCH.
  - j: PC <= {PC[31:28], target, 2'b00}; go to FETCH.
  - jal: as j, plus R[31] <= PC (old PC+4), written in this cycle; go to FETCH.
  - jr: PC <= A; go to FETCH.
  - lw/sw: ALUOut <= A + sext(imm); go to MEM.
  - R-type/addi/xori: ALUOut <= result; go to WB.
- MEM:
  - mem_req = 1, mem_addr = ALUOut, mem_we = (sw), mem_wdata = B.
  - On mem_ready: sw goes to FETCH; lw latches MDR <= mem_rdata and goes to WB.
- WB:
  - R-type writes R[rd] <= ALUOut; addi/xori write R[rt] <= ALUOut; lw writes R[rt] <= MDR.
  - Then go to FETCH.
- HALT: terminal. mem_req = 0; halted = 1; exit only by reset.
- R[0] always reads 0; writes to R[0] are discarded.
- Latency with zero-wait memory (mem_ready tied high):
  - branch/jump: 3 cycles.
  - R-type/addi/xori/sw: 4 cycles.
  - lw: 5 cycles.
  - Each memory stall cycle adds 1.
- mem_req is never asserted in the DECODE, EXEC or WB states.
- Address and data outputs must not change while mem_req is high and mem_ready is low.
- Unaligned addresses are passed through unchanged; alignment is the memory's responsibility.

Decomposition:
- Package mc_cpu_pkg:
  - opcode and funct constants.
  - state enum (3-bit).
  - ALU-op enum: ADD, SUB, SLT, XOR.
- Sub-module mc_cpu_regfile:
  - 32x32, two asynchronous read ports, one synchronous write port with enable.
  - R[0] hardwired to zero.

Test Plan:
- Reset during FETCH with mem_ready held low for 3 cycles -> mem_req falls in the same cycle as reset; after release, mem_addr = RESET_PC and pc_out = RESET_PC.
- Zero-wait program "addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1" -> R3 = 2, R4 = 1; total 16 cycles from first FETCH.
- sw $3,8($0) then lw $5,8($0), with mem_ready delayed 2 cycles on every access -> write seen at addr 8 with data 2; R5 = 2; address/data stable throughout every stall.
- beq $1,$1,-1 at PC 0x10 -> next fetch address 0x10. bne $1,$1,4 -> next fetch address PC+4 (not taken).
- jal to target 0x40 from PC 0x20 -> R31 = 0x24, next fetch 0x100. jr $31 -> next fetch 0x24.
- Illegal opcode 6'h3F with HALT_ON_ILLEGAL=1 -> halted = 1, no further mem_req. With HALT_ON_ILLEGAL=0 -> fetch continues at PC+4 with no register change.

Source files
------------

// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package mc_cpu_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_SLT = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_e;

    function automatic logic [31:0] alu_calc(alu_op_e op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_SUB: r = a - b;
            ALU_SLT: r = {31'd0, ($signed(a) < $signed(b))};
            ALU_XOR: r = a ^ b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    function automatic logic is_legal(logic [5:0] op, logic [5:0] fn);
        logic ok;
        case (op)
            OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT) || (fn == FN_JR);
            OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_XORI, OP_LW, OP_SW: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_cpu_regfile.sv
// 32x32 register file, two asynchronous read ports, one synchronous write port.
// Latency: reads combinational; a write is visible the cycle after we is sampled.
// Backpressure: none; writes to R0 are dropped and R0 always reads zero.
// Ports: clk; raddr1/raddr2 -> rdata1/rdata2; we/waddr/wdata write port.
module mc_cpu_regfile (
    input  logic        clk,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    // Contents deliberately survive reset.
    logic [31:0] regs_q [0:31];

    always_ff @(posedge clk) begin
        if (we && (waddr != 5'd0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs_q[raddr2];

endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle MIPS-subset core with one shared instruction/data memory port.
// Latency: branch/jump 3, ALU/sw 4, lw 5 cycles, plus one per memory stall cycle.
// Backpressure: mem_req/addr/we/wdata held stable until mem_ready; FSM waits in FETCH/MEM.
// Ports: clk, reset (async high); mem_* unified memory port; pc_out, halted, state_out debug.
module mc_cpu
    import mc_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MEM_ADDR_WIDTH  = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata,
    input  logic                      mem_ready,
    output logic [31:0]               pc_out,
    output logic                      halted,
    output logic [2:0]                state_out
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] mdr_q, mdr_d;

    // Instruction fields
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] imm_sext, imm_zext;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm      = ir_q[15:0];
    assign target   = ir_q[25:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'd0, imm};

    logic [31:0] rf_rdata1, rf_rdata2, rf_wdata;
    logic [4:0]  rf_waddr;
    logic        rf_we;

    mc_cpu_regfile u_rf (
        .clk    (clk),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata)
    );

    alu_op_e     alu_op;
    logic [31:0] alu_b;
    logic [31:0] alu_res;

    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = imm_sext;
        if (opcode == OP_RTYPE) begin
            alu_b = b_q;
            if (funct == FN_SUB)      alu_op = ALU_SUB;
            else if (funct == FN_SLT) alu_op = ALU_SLT;
        end else if (opcode == OP_XORI) begin
            alu_b  = imm_zext;
            alu_op = ALU_XOR;
        end
        alu_res = alu_calc(alu_op, a_q, alu_b);
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        rf_we     = 1'b0;
        rf_waddr  = 5'd0;
        rf_wdata  = alu_out_q;

        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = rf_rdata1;
                b_d = rf_rdata2;
                if (is_legal(opcode, funct)) state_d = S_EXEC;
                else if (HALT_ON_ILLEGAL)    state_d = S_HALT;
                else                         state_d = S_FETCH;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    // pc_q already points past the branch, so the offset is relative to PC+4.
                    OP_BEQ: if (a_q == b_q) pc_d = pc_q + {imm_sext[29:0], 2'b00};
                    OP_BNE: if (a_q != b_q) pc_d = pc_q + {imm_sext[29:0], 2'b00};
                    OP_J:   pc_d = {pc_q[31:28], target, 2'b00};
                    OP_JAL: begin
                        pc_d     = {pc_q[31:28], target, 2'b00};
                        rf_we    = 1'b1;
                        rf_waddr = 5'd31;
                        rf_wdata = pc_q;
                    end
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            pc_d = a_q;
                        end else begin
                            alu_out_d = alu_res;
                            state_d   = S_WB;
                        end
                    end
                    OP_ADDI, OP_XORI: begin
                        alu_out_d = alu_res;
                        state_d   = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_out_d = alu_res;
                        state_d   = S_MEM;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
                rf_wdata = (opcode == OP_LW) ? mdr_q : alu_out_q;
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            alu_out_q <= 32'd0;
            mdr_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
        end
    end

    // Port outputs decode only registered state; gating with reset makes an
    // in-flight request disappear the moment reset asserts.
    assign mem_req   = ~reset & ((state_q == S_FETCH) | (state_q == S_MEM));
    assign mem_we    = ~reset & (state_q == S_MEM) & (opcode == OP_SW);
    assign mem_addr  = (state_q == S_MEM) ? alu_out_q[MEM_ADDR_WIDTH-1:0] : pc_q[MEM_ADDR_WIDTH-1:0];
    assign mem_wdata = b_q;
    assign pc_out    = pc_q;
    assign halted    = (state_q == S_HALT);
    assign state_out = state_q;

endmodule

// File: tb/tb_mc_cpu.sv
// Directed bench for mc_cpu: reset, ALU program, stalled load/store, branches,
// jumps, and illegal-opcode handling on both HALT_ON_ILLEGAL settings.
// Memory model with programmable wait states and a stall-stability monitor.
module tb_mc_cpu;
    import mc_cpu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main DUT (halts on illegal opcode)
    logic        mem_req, mem_we, mem_ready, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
    logic [2:0]  state_out;

    mc_cpu dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc_out(pc_out), .halted(halted), .state_out(state_out)
    );

    // Second DUT treating illegal opcodes as NOPs, zero-wait memory
    logic        mem_req1, mem_we1, halted1;
    logic [31:0] mem_addr1, mem_wdata1, mem_rdata1, pc_out1;
    logic [2:0]  state_out1;
    logic [31:0] imem1 [0:255];

    mc_cpu #(.HALT_ON_ILLEGAL(1'b0)) dut1 (
        .clk(clk), .reset(reset), .mem_req(mem_req1), .mem_we(mem_we1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .mem_ready(1'b1), .pc_out(pc_out1), .halted(halted1), .state_out(state_out1)
    );
    assign mem_rdata1 = imem1[mem_addr1[9:2]];

    // Memory model for the main DUT: program image plus a store overlay
    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];
    logic        dwr  [0:255];
    logic        hold_low = 1'b0;
    int          wait_n   = 0;
    int          cnt      = 0;
    logic        pend     = 1'b0;
    logic [31:0] s_addr   = 32'd0;
    logic [31:0] s_wdata  = 32'd0;
    logic        s_we     = 1'b0;
    int          stab_err = 0;
    int          stall_cyc = 0;
    int          wr_cnt   = 0;
    logic [31:0] wr_addr  = 32'd0;
    logic [31:0] wr_data  = 32'd0;
    logic [7:0]  idx;

    assign idx       = mem_addr[9:2];
    assign mem_ready = !hold_low && (cnt >= wait_n);
    assign mem_rdata = dwr[idx] ? dmem[idx] : imem[idx];

    always @(posedge clk) begin
        if (reset) begin
            cnt  <= 0;
            pend <= 1'b0;
            for (int i = 0; i < 256; i++) dwr[i] <= 1'b0;
        end else begin
            if (pend && mem_req &&
                (mem_addr != s_addr || mem_we != s_we || (mem_we && mem_wdata != s_wdata)))
                stab_err <= stab_err + 1;
            if (mem_req && !mem_ready) begin
                cnt       <= cnt + 1;
                stall_cyc <= stall_cyc + 1;
                pend      <= 1'b1;
                s_addr    <= mem_addr;
                s_we      <= mem_we;
                s_wdata   <= mem_wdata;
            end else begin
                pend <= 1'b0;
                if (mem_req) cnt <= 0;
            end
            if (mem_req && mem_ready && mem_we) begin
                dmem[idx] <= mem_wdata;
                dwr[idx]  <= 1'b1;
                wr_cnt    <= wr_cnt + 1;
                wr_addr   <= mem_addr;
                wr_data   <= mem_wdata;
            end
        end
    end

    localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] t);
        return {op, t};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = ILLEGAL;
    endtask

    int wr0, st0;

    initial begin
        // Program for the NOP-on-illegal core
        for (int i = 0; i < 256; i++) imem1[i] = ILLEGAL;
        imem1[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd7);
        imem1[1] = 32'hFC21_FFFF;
        imem1[2] = enc_i(OP_ADDI, 5'd1, 5'd2, 16'd1);

        // ALU program
        clear_imem();
        imem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
        imem[1] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'hFFFD);
        imem[2] = enc_r(5'd1, 5'd2, 5'd3, FN_ADD);
        imem[3] = enc_r(5'd2, 5'd1, 5'd4, FN_SLT);

        // ---- Reset behaviour
        cyc(2);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_state", {29'd0, state_out}, {29'd0, S_FETCH});
        reset = 1'b0;
        #1;
        check("rel_req", {31'd0, mem_req}, 32'd1);
        check("rel_addr", mem_addr, 32'h0);
        cyc(4);
        check("pre_stall_addr", mem_addr, 32'h4);
        hold_low = 1'b1;
        cyc(3);
        check("stall_state", {29'd0, state_out}, {29'd0, S_FETCH});
        check("stall_addr", mem_addr, 32'h4);
        reset = 1'b1;
        #1;
        check("async_rst_req", {31'd0, mem_req}, 32'd0);
        check("async_rst_pc", pc_out, 32'h0);
        cyc(1);
        reset    = 1'b0;
        hold_low = 1'b0;
        #1;
        check("rel2_addr", mem_addr, 32'h0);
        check("rel2_pc", pc_out, 32'h0);
        check("rel2_req", {31'd0, mem_req}, 32'd1);

        // ---- Zero-wait ALU program: 4 instructions x 4 cycles
        cyc(15);
        check("alu_c15_state", {29'd0, state_out}, {29'd0, S_WB});
        cyc(1);
        check("alu_c16_state", {29'd0, state_out}, {29'd0, S_FETCH});
        check("alu_c16_addr", mem_addr, 32'h10);
        check("alu_r1", dut.u_rf.regs_q[1], 32'd5);
        check("alu_r2", dut.u_rf.regs_q[2], 32'hFFFF_FFFD);
        check("alu_r3", dut.u_rf.regs_q[3], 32'd2);
        check("alu_r4_slt", dut.u_rf.regs_q[4], 32'd1);
        cyc(2);
        check("ill_halted", {31'd0, halted}, 32'd1);
        check("ill_state", {29'd0, state_out}, {29'd0, S_HALT});
        cyc(3);
        check("halt_no_req", {31'd0, mem_req}, 32'd0);
        check("halt_pc", pc_out, 32'h14);

        // ---- sw/lw with two wait states on every access (R3 = 2 survives reset)
        reset = 1'b1;
        clear_imem();
        imem[0] = enc_i(OP_SW, 5'd0, 5'd3, 16'd8);
        imem[1] = enc_i(OP_LW, 5'd0, 5'd5, 16'd8);
        wait_n = 2;
        cyc(1);
        wr0 = wr_cnt;
        st0 = stall_cyc;
        reset = 1'b0;
        cyc(8);
        check("sw_done_addr", mem_addr, 32'h4);
        check("sw_count", wr_cnt - wr0, 32'd1);
        check("sw_addr", wr_addr, 32'h8);
        check("sw_data", wr_data, 32'd2);
        cyc(9);
        check("lw_done_state", {29'd0, state_out}, {29'd0, S_FETCH});
        check("lw_done_addr", mem_addr, 32'h8);
        check("lw_r5", dut.u_rf.regs_q[5], 32'd2);
        check("stall_cycles", stall_cyc - st0, 32'd8);
        check("stall_stable", stab_err, 32'd0);

        // ---- Branches: bne not taken, j, beq to itself
        reset = 1'b1;
        wait_n = 0;
        clear_imem();
        imem[0] = enc_i(OP_BNE, 5'd1, 5'd1, 16'd4);
        imem[1] = enc_j(OP_J, 26'h4);
        imem[4] = enc_i(OP_BEQ, 5'd1, 5'd1, 16'hFFFF);
        cyc(1);
        reset = 1'b0;
        cyc(3);
        check("bne_nt_addr", mem_addr, 32'h4);
        cyc(3);
        check("j_addr", mem_addr, 32'h10);
        cyc(1);
        check("beq_dec_pc", pc_out, 32'h14);
        cyc(2);
        check("beq_state", {29'd0, state_out}, {29'd0, S_FETCH});
        check("beq_addr", mem_addr, 32'h10);

        // ---- jal / jr, then sub and xori
        reset = 1'b1;
        clear_imem();
        imem[0]    = enc_j(OP_J, 26'h8);
        imem[8]    = enc_j(OP_JAL, 26'h40);
        imem[9]    = enc_r(5'd1, 5'd2, 5'd6, FN_SUB);
        imem[10]   = enc_i(OP_XORI, 5'd2, 5'd7, 16'hFFFF);
        imem[8'h40] = enc_r(5'd31, 5'd0, 5'd0, FN_JR);
        cyc(1);
        reset = 1'b0;
        cyc(3);
        check("j20_addr", mem_addr, 32'h20);
        cyc(3);
        check("jal_addr", mem_addr, 32'h100);
        check("jal_r31", dut.u_rf.regs_q[31], 32'h24);
        cyc(3);
        check("jr_addr", mem_addr, 32'h24);
        cyc(4);
        check("sub_addr", mem_addr, 32'h28);
        check("sub_r6", dut.u_rf.regs_q[6], 32'd8);
        cyc(4);
        check("xori_addr", mem_addr, 32'h2C);
        check("xori_r7", dut.u_rf.regs_q[7], 32'hFFFF_0002);
        cyc(2);
        check("jal_prog_halt", {31'd0, halted}, 32'd1);

        // ---- Illegal opcode as NOP (second core)
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(4);
        check("nop_first_addr", mem_addr1, 32'h4);
        check("nop_r1", dut1.u_rf.regs_q[1], 32'd7);
        cyc(2);
        check("nop_skip_state", {29'd0, state_out1}, {29'd0, S_FETCH});
        check("nop_skip_addr", mem_addr1, 32'h8);
        check("nop_not_halted", {31'd0, halted1}, 32'd0);
        cyc(4);
        check("nop_after_addr", mem_addr1, 32'hC);
        check("nop_r1_kept", dut1.u_rf.regs_q[1], 32'd7);
        check("nop_r2", dut1.u_rf.regs_q[2], 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
